pipe_alu_rf: RTL and testbench
==============================

Name: pipe_alu_rf

Overview:
- Single-clock, parametrised successor to the two-phase pipelined ALU.
- Three-stage pipeline: operand read from an internal register bank, ALU execute with register-bank write, then result store to an internal data memory.
- Adds generic data, register-count and memory widths, a valid qualifier, EX-to-ID forwarding for back-to-back dependencies, variable shifts, and a signed-overflow flag.

Parameters:
DW, 16, data width of registers, memory words and ALU (min 4)
RN, 16, number of registers (power of 2)
RW, 4, register index width, log2(RN)
AW, 8, data memory address width (depth 2**AW)

Ports:
clk1  input  1  rising-edge clock (sole clock)
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instruction present this cycle
rs1  input  RW  source register A
rs2  input  RW  source register B
rd  input  RW  destination register
func  input  4  operation code
addr  input  AW  memory address for result store
Zout  output  DW  ALU result of the instruction in WB
out_valid  output  1  Zout/out_rd/ovf refer to a valid instruction
out_rd  output  RW  destination of the instruction in WB
ovf  output  1  signed overflow (ADD/SUB only, else 0)
dbg_addr  input  AW  debug memory read address
dbg_data  output  DW  combinational mem[dbg_addr]

Behaviour:
- Reset (async, immediate): all stage valid bits 0; Zout=0, out_valid=0, out_rd=0, ovf=0; Reg[k]=k mod 2**DW for all k. Memory not reset; no memory write may occur while rst=1 or on the first edge after release.
- Stage ID (edge N, in_valid=1): latch func, rd, addr and operands A, B.
- Operand source, per operand, independently:
  - EX valid and rs == EX.rd -> combinational ALU result of the EX instruction (forwarding);
  - otherwise -> Reg[rs].
- Stage EX/WB (edge N+1): latch Zout, out_rd and ovf; assert out_valid; write Reg[rd]=result.
- Stage MEM (edge N+2): mem[addr]=stored result.
- Latency: Zout visible after 2 edges; memory updated after 3 edges.
- Throughput: 1 instruction/cycle; no backpressure.
- Bubbles (in_valid=0): propagate as invalid slots.
  - In WB: Zout, out_rd and ovf hold their previous values; out_valid=0; no register write.
  - In MEM: no memory write.
- Register write and operand read in the same edge resolve through forwarding; the register bank is never read stale.
- func encoding; results truncated to DW:
  - 0 ADD A+B; 1 SUB A-B; 2 MUL low DW bits of A*B
  - 3 A; 4 B; 5 A&B; 6 A|B; 7 A^B
  - 8 -A (two's complement); 9 ~B
  - 10 SRA A>>>1 (arithmetic); 11 SLA A<<1
  - 12 SLL A<<B[log2 DW-1:0]; 13 SRL A>>B[log2 DW-1:0] (logical)
  - 14 SLT (signed A<B ? 1 : 0); 15 A (reserved, no fault)
- ovf (ADD): operand signs equal and result sign differs.
- ovf (SUB): operand signs differ and result sign differs from A.
- Reset mid-stream: every in-flight instruction is discarded (no register or memory write). The first instruction after release sees the reset register values.
- rd equal to rs1/rs2 of the same instruction: reads the old value and writes the new one.
- Two consecutive writes to the same rd: the later one wins. Forwarding always selects the youngest producer.

Test Plan:
- Reset then ADD rs1=3 rs2=5 rd=10 addr=125 -> after 2 edges Zout=8, out_valid=1, out_rd=10; after 3 edges dbg_addr=125 reads 8; Reg[10]=8.
- Back-to-back dependency: ADD 3+5->r10, then next cycle SUB rs1=10 rs2=5 rd=14 addr=128 -> Zout=3 (forwarded, not 10-5=5); mem[128]=3.
- Function sweep, DW=16:
  - MUL r3*r8=24; SLA r7=14; SRA r15=7; SLL r1<<r4=16
  - SLT r2<r9 -> 1; SUB r0-r1=0xFFFF with ovf=0; 9 (~B) on r0 -> 0xFFFF
- Overflow, DW=8 instance: SLL r1<<r7 ->0x80 into r12; then ADD r12+r12 -> Zout=0, ovf=1; SUB r12-r1 -> 0x7F, ovf=1.
- Bubbles: ADD, idle, idle, SUB -> out_valid pulses 1,0,0,1; Zout holds 8 during idle cycles; no memory write at addresses from idle cycles.
- Reset mid-op: issue ADD to r10/addr 125 and SUB to r14/addr 128 (mem preloaded 0x55). Assert rst one edge after the SUB issues -> mem[125] and mem[128] stay 0x55; Reg[10]=10, Reg[14]=14; out_valid=0 immediately on rst.

Source files
------------

// File: rtl/pipe_alu_rf.sv
// Three-stage pipelined ALU: register read with EX forwarding, then execute
// and register write-back, then store of the result to an internal memory.
module pipe_alu_rf #(
  parameter int DW = 16,
  parameter int RN = 16,
  parameter int RW = 4,
  parameter int AW = 8
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [3:0]    func,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] Zout,
  output logic          out_valid,
  output logic [RW-1:0] out_rd,
  output logic          ovf,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int SW = $clog2(DW);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_A   = 4'd3,
    OP_B   = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,
    OP_NEG = 4'd8,  OP_NOT = 4'd9,  OP_SRA = 4'd10, OP_SLA = 4'd11,
    OP_SLL = 4'd12, OP_SRL = 4'd13, OP_SLT = 4'd14, OP_RSV = 4'd15
  } op_t;

  // Valid semantics: there is no backpressure. A slot carries an instruction
  // exactly when its valid bit is 1; an invalid slot never writes state.
  logic          ex_valid;
  logic [3:0]    ex_func;
  logic [RW-1:0] ex_rd;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_a, ex_b;
  logic [AW-1:0] wb_addr;

  logic [DW-1:0] rf  [RN];
  logic [DW-1:0] mem [2**AW];

  logic [DW-1:0] alu_res;
  logic          alu_ovf;
  logic [DW-1:0] op_a, op_b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_t'(ex_func))
      OP_ADD: begin
        alu_res = ex_a + ex_b;
        alu_ovf = (ex_a[DW-1] == ex_b[DW-1]) && (alu_res[DW-1] != ex_a[DW-1]);
      end
      OP_SUB: begin
        alu_res = ex_a - ex_b;
        alu_ovf = (ex_a[DW-1] != ex_b[DW-1]) && (alu_res[DW-1] != ex_a[DW-1]);
      end
      OP_MUL: alu_res = ex_a * ex_b;
      OP_A:   alu_res = ex_a;
      OP_B:   alu_res = ex_b;
      OP_AND: alu_res = ex_a & ex_b;
      OP_OR:  alu_res = ex_a | ex_b;
      OP_XOR: alu_res = ex_a ^ ex_b;
      OP_NEG: alu_res = -ex_a;
      OP_NOT: alu_res = ~ex_b;
      OP_SRA: alu_res = DW'($signed(ex_a) >>> 1);
      OP_SLA: alu_res = ex_a << 1;
      OP_SLL: alu_res = ex_a << ex_b[SW-1:0];
      OP_SRL: alu_res = ex_a >> ex_b[SW-1:0];
      OP_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      default: alu_res = ex_a;
    endcase
  end

  // The EX instruction writes the bank on the same edge this read is latched,
  // so its result is taken straight from the ALU instead of the bank.
  always_comb begin
    op_a = (ex_valid && (rs1 == ex_rd)) ? alu_res : rf[rs1];
    op_b = (ex_valid && (rs2 == ex_rd)) ? alu_res : rf[rs2];
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_func   <= '0;
      ex_rd     <= '0;
      ex_addr   <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      out_valid <= 1'b0;
      Zout      <= '0;
      out_rd    <= '0;
      ovf       <= 1'b0;
      wb_addr   <= '0;
      for (int k = 0; k < RN; k++) rf[k] <= DW'(k);
    end else begin
      ex_valid  <= in_valid;
      out_valid <= ex_valid;
      if (in_valid) begin
        ex_func <= func;
        ex_rd   <= rd;
        ex_addr <= addr;
        ex_a    <= op_a;
        ex_b    <= op_b;
      end
      if (ex_valid) begin
        Zout       <= alu_res;
        out_rd     <= ex_rd;
        ovf        <= alu_ovf;
        wb_addr    <= ex_addr;
        rf[ex_rd]  <= alu_res;
      end
    end
  end

  // Memory is not reset; out_valid drops asynchronously with rst, so no
  // in-flight result can be stored once reset is seen.
  always_ff @(posedge clk1) begin
    if (out_valid && !rst) mem[wb_addr] <= Zout;
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_pipe_alu_rf.sv
// Directed bench for pipe_alu_rf: a DW=16 instance for the main function and
// a DW=8 instance sharing the same stimulus for the overflow cases.
module tb_pipe_alu_rf;

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] rs1 = '0, rs2 = '0, rd = '0, func = '0;
  logic [7:0] addr = '0, dbg_addr = '0;

  logic [15:0] zout_a, dbg_a;
  logic        ov_a, ovf_a;
  logic [3:0]  rd_a;
  logic [7:0]  zout_b, dbg_b;
  logic        ov_b, ovf_b;
  logic [3:0]  rd_b;

  int total = 0;
  int bad = 0;

  always #5 clk1 = ~clk1;

  pipe_alu_rf #(.DW(16), .RN(16), .RW(4), .AW(8)) dut_a (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .Zout(zout_a), .out_valid(ov_a), .out_rd(rd_a),
    .ovf(ovf_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  pipe_alu_rf #(.DW(8), .RN(16), .RW(4), .AW(8)) dut_b (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .Zout(zout_b), .out_valid(ov_b), .out_rd(rd_b),
    .ovf(ovf_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  typedef struct packed {
    logic [3:0]  f;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  d;
    logic [15:0] z;
  } vec_t;

  // Register state when the sweep runs: r_k = k except r10 = 8, r14 = 3.
  vec_t sweep [16] = '{
    '{4'd2,  4'd3,  4'd8, 4'd11, 16'd24},
    '{4'd11, 4'd7,  4'd0, 4'd12, 16'd14},
    '{4'd10, 4'd15, 4'd0, 4'd13, 16'd7},
    '{4'd12, 4'd1,  4'd4, 4'd11, 16'd16},
    '{4'd14, 4'd2,  4'd9, 4'd12, 16'd1},
    '{4'd1,  4'd0,  4'd1, 4'd13, 16'hFFFF},
    '{4'd9,  4'd0,  4'd0, 4'd11, 16'hFFFF},
    '{4'd3,  4'd10, 4'd0, 4'd12, 16'd8},
    '{4'd7,  4'd5,  4'd6, 4'd13, 16'd3},
    '{4'd5,  4'd7,  4'd5, 4'd11, 16'd5},
    '{4'd6,  4'd8,  4'd1, 4'd12, 16'd9},
    '{4'd8,  4'd1,  4'd0, 4'd13, 16'hFFFF},
    '{4'd13, 4'd15, 4'd2, 4'd11, 16'd3},
    '{4'd4,  4'd0,  4'd9, 4'd12, 16'd9},
    '{4'd15, 4'd6,  4'd0, 4'd13, 16'd6},
    '{4'd14, 4'd15, 4'd14, 4'd11, 16'd0}
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [7:0] ad);
    @(negedge clk1);
    in_valid = 1'b1;
    func = f; rs1 = a; rs2 = b; rd = d; addr = ad;
  endtask

  task automatic idle(input logic [7:0] ad);
    @(negedge clk1);
    in_valid = 1'b0;
    addr = ad;
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic mem_chk(input string tag, input logic [7:0] ad, input logic [15:0] exp);
    dbg_addr = ad;
    #1;
    chk(tag, dbg_a, exp);
  endtask

  initial begin
    // clock/reset
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    chk("rst_zout", zout_a, 0);
    chk("rst_valid", ov_a, 0);
    chk("rst_rd", rd_a, 0);
    chk("rst_ovf", ovf_a, 0);

    // single ADD, then a forwarded SUB
    issue(4'd0, 4'd3, 4'd5, 4'd10, 8'd125);
    issue(4'd1, 4'd10, 4'd5, 4'd14, 8'd128);
    idle(8'd128);
    chk("add_zout", zout_a, 8);
    chk("add_valid", ov_a, 1);
    chk("add_rd", rd_a, 10);
    chk("add_ovf", ovf_a, 0);
    idle(8'd128);
    chk("fwd_zout", zout_a, 3);
    chk("fwd_rd", rd_a, 14);
    mem_chk("add_mem125", 8'd125, 16'd8);
    idle(8'd128);
    chk("tail_valid", ov_a, 0);
    chk("tail_hold", zout_a, 3);
    mem_chk("fwd_mem128", 8'd128, 16'd3);

    // function sweep, results checked two cycles behind issue
    for (int i = 0; i < 18; i++) begin
      if (i < 16) issue(sweep[i].f, sweep[i].a, sweep[i].b, sweep[i].d, 8'(10 + i));
      else idle(8'd10);
      if (i >= 2) begin
        chk($sformatf("sweep%0d_zout", i - 2), zout_a, sweep[i-2].z);
        chk($sformatf("sweep%0d_rd", i - 2), rd_a, sweep[i-2].d);
        chk($sformatf("sweep%0d_ovf", i - 2), ovf_a, 0);
      end
    end

    // bubbles between two instructions
    issue(4'd0, 4'd3, 4'd5, 4'd10, 8'd130);
    idle(8'd128);
    idle(8'd128);
    chk("bub_v0", ov_a, 1);
    chk("bub_z0", zout_a, 8);
    issue(4'd1, 4'd10, 4'd5, 4'd14, 8'd131);
    chk("bub_v1", ov_a, 0);
    chk("bub_z1", zout_a, 8);
    idle(8'd128);
    chk("bub_v2", ov_a, 0);
    chk("bub_z2", zout_a, 8);
    idle(8'd128);
    chk("bub_v3", ov_a, 1);
    chk("bub_z3", zout_a, 3);
    idle(8'd128);
    idle(8'd128);
    mem_chk("bub_mem128", 8'd128, 16'd3);
    mem_chk("bub_mem130", 8'd130, 16'd8);
    mem_chk("bub_mem131", 8'd131, 16'd3);

    // signed overflow on the DW=8 instance
    do_reset();
    issue(4'd12, 4'd1, 4'd7, 4'd12, 8'd50);
    issue(4'd0, 4'd12, 4'd12, 4'd13, 8'd51);
    issue(4'd1, 4'd12, 4'd1, 4'd14, 8'd52);
    chk("ov8_sll", zout_b, 8'h80);
    chk("ov8_sll_ovf", ovf_b, 0);
    idle(8'd0);
    chk("ov8_add", zout_b, 8'h00);
    chk("ov8_add_ovf", ovf_b, 1);
    chk("ov8_add_rd", rd_b, 13);
    chk("ov16_add", zout_a, 16'h0100);
    chk("ov16_add_ovf", ovf_a, 0);
    idle(8'd0);
    chk("ov8_sub", zout_b, 8'h7F);
    chk("ov8_sub_ovf", ovf_b, 1);
    chk("ov8_sub_valid", ov_b, 1);
    idle(8'd0);
    dbg_addr = 8'd52;
    #1;
    chk("ov8_mem52", dbg_b, 8'h7F);

    // reset while instructions are in flight
    do_reset();
    issue(4'd12, 4'd5, 4'd4, 4'd11, 8'd0);
    issue(4'd6, 4'd11, 4'd5, 4'd11, 8'd125);
    issue(4'd3, 4'd11, 4'd0, 4'd11, 8'd128);
    idle(8'd0);
    idle(8'd0);
    idle(8'd0);
    mem_chk("pre_mem0", 8'd0, 16'h0050);
    mem_chk("pre_mem125", 8'd125, 16'h0055);
    mem_chk("pre_mem128", 8'd128, 16'h0055);
    issue(4'd0, 4'd3, 4'd5, 4'd10, 8'd125);
    issue(4'd1, 4'd10, 4'd5, 4'd14, 8'd128);
    @(negedge clk1);
    chk("mid_valid_pre", ov_a, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_valid_rst", ov_a, 0);
    chk("mid_zout_rst", zout_a, 0);
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    mem_chk("mid_mem125", 8'd125, 16'h0055);
    mem_chk("mid_mem128", 8'd128, 16'h0055);
    mem_chk("mid_mem0", 8'd0, 16'h0050);
    issue(4'd3, 4'd10, 4'd0, 4'd10, 8'd200);
    issue(4'd3, 4'd14, 4'd0, 4'd14, 8'd201);
    idle(8'd0);
    chk("mid_r10", zout_a, 10);
    idle(8'd0);
    chk("mid_r14", zout_a, 14);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
